pim_cfu_cmd_issuer: RTL and testbench

//   Initiator side of the PIM CFU cmd/rsp protocol. It queues host commands (read/write/MAC)
//   in a small FIFO and issues them one at a time to the cfu responder using a valid/ready handshake.
//   It collects each response, returns it to the host on a result port, and reports stalled

---
 rtl/pim_cfu_pkg.sv | 20 ++
 rtl/pim_cfu_cmd_issuer_if.sv | 33 +++
 rtl/pim_cmd_fifo.sv | 54 +++++
 rtl/pim_cfu_cmd_issuer.sv | 156 +++++++++++++++
 tb/tb_pim_cfu_cmd_issuer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_cfu_pkg.sv
// Shared definitions for the PIM CFU command/response protocol.
// Function-id encoding and issuer FSM states.
package pim_cfu_pkg;

  localparam logic [1:0] FN_READ    = 2'b00;
  localparam logic [1:0] FN_WRITE   = 2'b01;
  localparam int         FN_MAC_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  function automatic logic fn_is_mac(input logic [1:0] fn);
    return fn[FN_MAC_BIT];
  endfunction

endpackage

// File: rtl/pim_cfu_cmd_issuer_if.sv
// CFU-side cmd/rsp bus of the PIM CFU protocol.
// master = command issuer, slave = cfu responder.
interface pim_cfu_cmd_issuer_if #(
  parameter int AWIDTH = 10,
  parameter int PWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AWIDTH-1:0] cmd_payload_function_id;
  logic [PWIDTH-1:0] cmd_payload_inputs_0;
  logic [PWIDTH-1:0] cmd_payload_inputs_1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_payload_response_ok;
  logic [DWIDTH-1:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id,
    output cmd_payload_inputs_0, cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_payload_response_ok, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id,
    input  cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_payload_response_ok, rsp_payload_outputs_0
  );
endinterface

// File: rtl/pim_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth.
// full/empty come straight from the pointer registers.
module pim_cmd_fifo #(
  parameter int W     = 74,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wptr_q, wptr_d;
  logic [PW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PW-1:0]];

  // Advance pointers on accepted push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (PW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (PW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pim_cfu_cmd_issuer.sv
// PIM CFU command issuer: queues host commands and
// runs one cmd/rsp exchange at a time with timeout.
import pim_cfu_pkg::*;

module pim_cfu_cmd_issuer #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 10,
  parameter int PWIDTH  = 32,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [AWIDTH-1:0]    q_func,
  input  logic [PWIDTH-1:0]    q_in0,
  input  logic [PWIDTH-1:0]    q_in1,
  pim_cfu_cmd_issuer_if.master cfu,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DWIDTH-1:0]    res_data,
  output logic                 res_err,
  output logic                 busy,
  output logic [15:0]          mac_cnt
);
  localparam int FW = AWIDTH + 2 * PWIDTH;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] func_q, func_d;
  logic [PWIDTH-1:0] in0_q, in0_d;
  logic [PWIDTH-1:0] in1_q, in1_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       mac_q, mac_d;

  logic          pop, full, empty, tmo_hit;
  logic [FW-1:0] fifo_rdata;

  pim_cmd_fifo #(
    .W     (FW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_valid),
    .pop   (pop),
    .wdata ({q_func, q_in0, q_in1}),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  // Counter sits at TIMEOUT at most, so a late cmd
  // handshake still times out in RSP next cycle.
  assign tmo_hit = (TIMEOUT != 0) &&
                   (int'(tmo_q) >= TIMEOUT - 1);

  // Next-state, payload, result and counter logic.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    mac_d   = mac_q;
    pop     = 1'b0;
    if ((state_q == ST_CMD || state_q == ST_RSP) &&
        int'(tmo_q) < TIMEOUT)
      tmo_d = tmo_q + TW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          {func_d, in0_d, in1_d} = fifo_rdata;
          tmo_d   = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cfu.cmd_ready && cfu.rsp_valid) begin
          data_d  = cfu.rsp_payload_outputs_0;
          err_d   = !cfu.rsp_payload_response_ok;
          state_d = ST_OUT;
        end else if (cfu.cmd_ready) begin
          state_d = ST_RSP;
        end else if (tmo_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_RSP: begin
        if (cfu.rsp_valid) begin
          data_d  = cfu.rsp_payload_outputs_0;
          err_d   = !cfu.rsp_payload_response_ok;
          state_d = ST_OUT;
        end else if (tmo_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          if (fn_is_mac(func_q[1:0]) && !err_q)
            mac_d = mac_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      mac_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      mac_q   <= mac_d;
    end
  end

  assign q_ready   = !full;
  assign res_valid = (state_q == ST_OUT);
  assign res_data  = data_q;
  assign res_err   = err_q;
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign mac_cnt   = mac_q;

  assign cfu.cmd_valid = (state_q == ST_CMD);
  assign cfu.rsp_ready = (state_q == ST_CMD) ||
                         (state_q == ST_RSP);
  assign cfu.cmd_payload_function_id = func_q;
  assign cfu.cmd_payload_inputs_0    = in0_q;
  assign cfu.cmd_payload_inputs_1    = in1_q;

endmodule

// File: tb/tb_pim_cfu_cmd_issuer.sv
// Bench for pim_cfu_cmd_issuer: cfu responder model,
// host scoreboard, directed and random traffic.
module tb_pim_cfu_cmd_issuer;
  import pim_cfu_pkg::*;

  localparam int AW = 10;
  localparam int PW = 32;
  localparam int DW = 32;
  localparam int M_RAND  = 0;
  localparam int M_STALL = 1;
  localparam int M_ZL    = 2;
  localparam int M_NORSP = 3;

  logic clk;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [AW-1:0] q_func  = '0;
  logic [PW-1:0] q_in0   = '0;
  logic [PW-1:0] q_in1   = '0;
  logic          res_valid, res_err, busy;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [15:0]   mac_cnt;

  logic          t_q_valid = 1'b0;
  logic          t_q_ready;
  logic [AW-1:0] t_q_func  = '0;
  logic [PW-1:0] t_q_in0   = '0;
  logic [PW-1:0] t_q_in1   = '0;
  logic          t_res_valid, t_res_err, t_busy;
  logic          t_res_ready = 1'b0;
  logic [DW-1:0] t_res_data;
  logic [15:0]   t_mac_cnt;

  pim_cfu_cmd_issuer_if #(.AWIDTH(AW), .PWIDTH(PW), .DWIDTH(DW)) cfu_if ();
  pim_cfu_cmd_issuer_if #(.AWIDTH(AW), .PWIDTH(PW), .DWIDTH(DW)) tcfu_if ();

  pim_cfu_cmd_issuer #(
    .DWIDTH(DW), .AWIDTH(AW), .PWIDTH(PW), .QDEPTH(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset),
    .q_valid(q_valid), .q_ready(q_ready), .q_func(q_func),
    .q_in0(q_in0), .q_in1(q_in1), .cfu(cfu_if),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .busy(busy), .mac_cnt(mac_cnt)
  );

  pim_cfu_cmd_issuer #(
    .DWIDTH(DW), .AWIDTH(AW), .PWIDTH(PW), .QDEPTH(4), .TIMEOUT(8)
  ) dut_tmo (
    .clk(clk), .reset(reset),
    .q_valid(t_q_valid), .q_ready(t_q_ready), .q_func(t_q_func),
    .q_in0(t_q_in0), .q_in1(t_q_in1), .cfu(tcfu_if),
    .res_valid(t_res_valid), .res_ready(t_res_ready),
    .res_data(t_res_data), .res_err(t_res_err),
    .busy(t_busy), .mac_cnt(t_mac_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench hang");
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        mac;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mmem [16];
  logic [31:0] rmem [16];
  int          exp_mac   = 0;
  int          mode      = M_RAND;
  logic        sink_hold = 1'b0;
  int          acc_cnt   = 0;
  int          n_push    = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: commands take effect strictly in push order.
  task automatic model_push(input logic [AW-1:0] f,
                            input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [3:0] ad;
    ad    = b[3:0];
    e.mac = f[FN_MAC_BIT];
    e.err = (f[9:8] == 2'b11);
    if (e.err)                   e.data = ~a;
    else if (f[FN_MAC_BIT])      e.data = mmem[ad] + a * b;
    else if (f[1:0] == FN_WRITE) e.data = a;
    else                         e.data = mmem[ad];
    if (!e.err && f[1:0] != FN_READ) mmem[ad] = e.data;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [AW-1:0] f,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    q_valid = 1'b1; q_func = f; q_in0 = a; q_in1 = b;
    while (!q_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("push_wait_q_ready", 0, 1);
    model_push(f, a, b);
    n_push++;
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
  endtask

  // CFU responder model for the main instance.
  initial begin
    logic        pend, pok, zl_chk, rok;
    int          lat, stall_n;
    logic [31:0] pdata, r, a, b;
    logic [AW-1:0] f;
    logic [3:0]  ad;
    logic [73:0] ref_pay;
    pend = 0; zl_chk = 0; lat = 0; stall_n = 0;
    cfu_if.cmd_ready = 0;
    cfu_if.rsp_valid = 0;
    cfu_if.rsp_payload_response_ok = 0;
    cfu_if.rsp_payload_outputs_0 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; zl_chk = 0; stall_n = 0;
        cfu_if.cmd_ready = 0;
        cfu_if.rsp_valid = 0;
        continue;
      end
      if (zl_chk) begin
        chk("zero_lat_res_valid", res_valid, 1);
        zl_chk = 0;
      end
      f = cfu_if.cmd_payload_function_id;
      a = cfu_if.cmd_payload_inputs_0;
      b = cfu_if.cmd_payload_inputs_1;
      if (pend) cfu_if.cmd_ready = 0;
      else if (mode == M_STALL) begin
        if (stall_n == 0 && cfu_if.cmd_valid) ref_pay = {f, a, b};
        if (stall_n > 0) begin
          chk("bp_cmd_valid", cfu_if.cmd_valid, 1);
          chk("bp_payload", {f, a, b}, ref_pay);
        end
        if (cfu_if.cmd_valid || stall_n > 0) begin
          if (stall_n < 10) begin
            cfu_if.cmd_ready = 0;
            stall_n++;
          end else cfu_if.cmd_ready = 1;
        end else cfu_if.cmd_ready = 0;
      end else if (mode == M_RAND)
        cfu_if.cmd_ready = ($urandom_range(0, 2) != 0);
      else cfu_if.cmd_ready = 1;
      if (pend && lat == 0) begin
        cfu_if.rsp_valid = 1;
        cfu_if.rsp_payload_outputs_0 = pdata;
        cfu_if.rsp_payload_response_ok = pok;
      end else cfu_if.rsp_valid = 0;
      if (cfu_if.rsp_valid && cfu_if.rsp_ready) pend = 0;
      else if (pend && lat > 0) lat--;
      if (cfu_if.cmd_valid && cfu_if.cmd_ready) begin
        acc_cnt++;
        stall_n = 0;
        ad  = b[3:0];
        rok = (f[9:8] != 2'b11);
        case (f[1:0])
          FN_READ:  r = rmem[ad];
          FN_WRITE: r = a;
          default:  r = a * b + rmem[ad];
        endcase
        if (!rok) r = ~a;
        else if (f[1:0] != FN_READ) rmem[ad] = r;
        if (mode == M_ZL) begin
          cfu_if.rsp_valid = 1;
          cfu_if.rsp_payload_outputs_0 = r;
          cfu_if.rsp_payload_response_ok = rok;
          zl_chk = 1;
        end else begin
          pend  = 1;
          pdata = r;
          pok   = rok;
          lat   = (mode == M_NORSP) ? 1000000 : $urandom_range(0, 3);
        end
      end
    end
  end

  // Host result sink and scoreboard for the main instance.
  initial begin
    exp_t        e;
    logic        seen, mac_due, hold_e;
    logic [31:0] hold_d;
    seen = 0; mac_due = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        res_ready = 0; seen = 0; mac_due = 0;
        continue;
      end
      if (mac_due) begin
        chk("mac_cnt", mac_cnt, exp_mac[15:0]);
        mac_due = 0;
      end
      if (res_valid) begin
        if (seen) begin
          chk("res_data_stable", res_data, hold_d);
          chk("res_err_stable", res_err, hold_e);
        end
        seen = 1; hold_d = res_data; hold_e = res_err;
        res_ready = !sink_hold && ($urandom_range(0, 3) != 0);
        if (res_ready) begin
          seen = 0;
          last_data = res_data;
          if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_err", res_err, e.err);
            if (e.mac && !e.err) exp_mac = (exp_mac + 1) & 16'hFFFF;
            mac_due = 1;
          end
        end
      end else res_ready = ($urandom_range(0, 1) != 0);
    end
  end

  initial begin
    logic [AW-1:0] f;
    int            n;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 32'h100 + i;
      rmem[i] = 32'h100 + i;
    end
    tcfu_if.cmd_ready = 1;
    tcfu_if.rsp_valid = 0;
    tcfu_if.rsp_payload_response_ok = 1;
    tcfu_if.rsp_payload_outputs_0 = 32'hA5A5_A5A5;

    repeat (3) @(negedge clk);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_cmd_valid", cfu_if.cmd_valid, 0);
    chk("rst_rsp_ready", cfu_if.rsp_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_cnt", mac_cnt, 0);
    chk("rst_cmd_func", cfu_if.cmd_payload_function_id, 0);
    reset = 0;
    @(negedge clk);

    // Write then read, plus issue latency.
    push({8'h00, FN_WRITE}, 32'hDEAD_BEEF, 32'd5);
    chk("lat_cmd_valid_1", cfu_if.cmd_valid, 0);
    push({8'h00, FN_READ}, 32'h0, 32'd5);
    chk("lat_cmd_valid_2", cfu_if.cmd_valid, 1);
    drain();
    chk("wr_rd_cfu_mem5", rmem[5], 32'hDEAD_BEEF);
    chk("wr_rd_last_data", last_data, 32'hDEAD_BEEF);

    // Backpressure.
    mode = M_STALL;
    n = acc_cnt;
    push({8'h00, FN_WRITE}, 32'h0BAD_F00D, 32'd3);
    drain();
    chk("bp_one_accept", acc_cnt - n, 1);
    mode = M_RAND;

    // FIFO full with host holding results.
    sink_hold = 1;
    for (int i = 0; i < 5; i++)
      push({8'h00, 2'b10}, 32'd3 + i, 32'd9);
    chk("full_q_ready", q_ready, 0);
    chk("full_busy", busy, 1);
    repeat (6) @(negedge clk);
    chk("full_q_ready_hold", q_ready, 0);
    sink_hold = 0;
    drain();

    // Timeout on the TIMEOUT=8 instance.
    t_q_valid = 1; t_q_func = {8'h00, 2'b10};
    t_q_in0 = 32'h11; t_q_in1 = 32'h2;
    @(negedge clk);
    t_q_valid = 0;
    @(negedge clk);
    chk("tmo_cmd_valid", tcfu_if.cmd_valid, 1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("tmo_res_valid_early", t_res_valid, 0);
      if (k == 1) chk("tmo_cmd_valid_drop", tcfu_if.cmd_valid, 0);
    end
    @(negedge clk);
    chk("tmo_res_valid", t_res_valid, 1);
    chk("tmo_res_err", t_res_err, 1);
    chk("tmo_res_data", t_res_data, 0);
    t_res_ready = 1;
    @(negedge clk);
    t_res_ready = 0;
    chk("tmo_busy_after", t_busy, 0);
    chk("tmo_mac_cnt", t_mac_cnt, 0);

    // Zero-latency responder.
    push({8'h00, FN_WRITE}, 32'h1234, 32'd7);
    drain();
    mode = M_ZL;
    push({8'h00, FN_READ}, 32'h0, 32'd7);
    drain();
    chk("zl_last_data", last_data, 32'h1234);
    mode = M_RAND;

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      f = {2'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)};
      push(f, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("accept_count", acc_cnt, n_push);

    // Reset while waiting in RSP.
    push({8'h00, 2'b10}, 32'h5, 32'h6);
    drain();
    chk("pre_rst_mac_nonzero", mac_cnt != 16'd0, 1);
    mode = M_NORSP;
    push({8'h00, 2'b10}, 32'h7, 32'h8);
    n = 0;
    while (!(cfu_if.rsp_ready && !cfu_if.cmd_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rsp", n < 100, 1);
    reset = 1;
    @(negedge clk);
    exp_q.delete();
    exp_mac = 0;
    chk("mrst_cmd_valid", cfu_if.cmd_valid, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_q_ready", q_ready, 1);
    chk("mrst_mac_cnt", mac_cnt, 0);
    reset = 0;
    mode = M_RAND;
    @(negedge clk);
    push({8'h00, FN_READ}, 32'h0, 32'h8);
    drain();
    chk("post_rst_read", last_data, mmem[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
